// File: rtl/z80_int_ctrl_if.sv
// Z80 CPU-side bus seen by the interrupt controller: I/O strobes, M1, address, data and vector return path.
interface z80_int_ctrl_if;
    logic [7:0] ADDRESS;
    logic [7:0] DATA_IN;
    logic       nIORQ;
    logic       nRD;
    logic       nWR;
    logic       m1_n;
    logic [7:0] DATA_OUT;
    logic       DATA_OE;

    modport master (
        output ADDRESS, DATA_IN, nIORQ, nRD, nWR, m1_n,
        input  DATA_OUT, DATA_OE
    );

    modport slave (
        input  ADDRESS, DATA_IN, nIORQ, nRD, nWR, m1_n,
        output DATA_OUT, DATA_OE
    );
endinterface

// File: rtl/z80_int_ctrl.sv
// Vectored IM2 interrupt controller with mask/pending/in-service I/O ports; optional IRQ_SYNC_EN adds input synchronisers.
// Latency: IRQ_IN rise -> pending 1 edge, -> nINT low 2 edges (3 and 4 edges with IRQ_SYNC_EN); vector/read data combinational.
// Backpressure: none; the CPU bus strobes are always accepted and the vector is held stable for the whole ack cycle.
module z80_int_ctrl #(
    parameter int         NUM_SRC  = 8,
    parameter logic [7:0] VEC_BASE = 8'h00,
    parameter logic [7:0] IO_BASE  = 8'hE0
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_SRC-1:0] IRQ_IN,
    output logic               nINT,
    z80_int_ctrl_if.slave      bus
);

    logic [NUM_SRC-1:0] irq_s;
    logic [NUM_SRC-1:0] irq_prev;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_SRC-1:0] isr;
    logic [NUM_SRC-1:0] isr_nxt;
    logic [NUM_SRC-1:0] allow;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] win_oh;
    logic [2:0]         win_idx;
    logic               win_any;
    logic [7:0]         vec_now;
    logic [7:0]         vec_q;
    logic [7:0]         rd_dat;
    logic               ack;
    logic               ack_d;
    logic               ack_start;
    logic               io_sel;
    logic               rd_en;
    logic               wr_en;
    logic               wr_d;
    logic               wr_start;
    logic [1:0]         offset;

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] irq_meta;
    logic [NUM_SRC-1:0] irq_sync;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            irq_meta <= '0;
            irq_sync <= '0;
        end else begin
            irq_meta <= IRQ_IN;
            irq_sync <= irq_meta;
        end
    end

    assign irq_s = irq_sync;
`else
    assign irq_s = IRQ_IN;
`endif

    assign rise = irq_s & ~irq_prev;

    // Only sources strictly above the highest-priority in-service bit may nest; isr==0 allows all.
    assign allow    = (isr & (~isr + NUM_SRC'(1))) - NUM_SRC'(1);
    assign eligible = pending & mask & allow;
    assign win_oh   = eligible & (~eligible + NUM_SRC'(1));
    assign win_any  = |eligible;

    always_comb begin
        win_idx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) win_idx = 3'(i);
        end
    end

    assign vec_now = win_any ? (VEC_BASE | {4'b0000, win_idx, 1'b0}) : (VEC_BASE | 8'hFE);

    assign ack       = !bus.m1_n && !bus.nIORQ;
    assign ack_start = ack && !ack_d;
    assign io_sel    = !bus.nIORQ && bus.m1_n && (bus.ADDRESS[7:2] == IO_BASE[7:2]);
    assign rd_en     = io_sel && !bus.nRD;
    assign wr_en     = io_sel && !bus.nWR;
    assign wr_start  = wr_en && !wr_d;
    assign offset    = bus.ADDRESS[1:0];

    always_comb begin
        pending_nxt = pending;
        if (ack_start) pending_nxt = pending_nxt & ~win_oh;
        if (wr_start && offset == 2'd1) pending_nxt = pending_nxt & ~bus.DATA_IN[NUM_SRC-1:0];
        pending_nxt = pending_nxt | rise;
    end

    always_comb begin
        isr_nxt = isr;
        if (ack_start) isr_nxt = isr | win_oh;
        else if (wr_start && offset == 2'd2) isr_nxt = isr & (isr - NUM_SRC'(1));
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            irq_prev <= '0;
            mask     <= '0;
            pending  <= '0;
            isr      <= '0;
            nINT     <= 1'b1;
            ack_d    <= 1'b0;
            wr_d     <= 1'b0;
            vec_q    <= 8'h00;
        end else begin
            irq_prev <= irq_s;
            pending  <= pending_nxt;
            isr      <= isr_nxt;
            nINT     <= !win_any;
            ack_d    <= ack;
            wr_d     <= wr_en;
            if (ack_start) vec_q <= vec_now;
            if (wr_start && offset == 2'd0) mask <= bus.DATA_IN[NUM_SRC-1:0];
        end
    end

    always_comb begin
        case (offset)
            2'd0:    rd_dat = 8'(mask);
            2'd1:    rd_dat = 8'(pending);
            2'd2:    rd_dat = 8'(isr);
            default: rd_dat = 8'hFF;
        endcase
    end

    // First ack cycle shows the live vector; afterwards the latched copy keeps it frozen.
    always_comb begin
        bus.DATA_OE  = 1'b0;
        bus.DATA_OUT = 8'h00;
        if (!RESET) begin
            if (ack) begin
                bus.DATA_OE  = 1'b1;
                bus.DATA_OUT = ack_start ? vec_now : vec_q;
            end else if (rd_en) begin
                bus.DATA_OE  = 1'b1;
                bus.DATA_OUT = rd_dat;
            end
        end
    end

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Directed bench for z80_int_ctrl: vectoring, nesting, EOI, W1C, spurious ack and mid-ack reset.
module tb_z80_int_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int EXP_LAT = 4;
`else
    localparam int EXP_LAT = 2;
`endif

    logic       CLK;
    logic       RESET;
    logic [7:0] IRQ_IN;
    logic       nINT;
    int         n_tests;
    int         n_fail;
    int         lat;

    z80_int_ctrl_if bus_if ();

    z80_int_ctrl dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .IRQ_IN (IRQ_IN),
        .nINT   (nINT),
        .bus    (bus_if)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic io_wr(input logic [7:0] addr, input logic [7:0] dat, input int hold = 1);
        @(negedge CLK);
        bus_if.ADDRESS = addr;
        bus_if.DATA_IN = dat;
        bus_if.nIORQ   = 1'b0;
        bus_if.nWR     = 1'b0;
        repeat (hold) @(negedge CLK);
        bus_if.nIORQ   = 1'b1;
        bus_if.nWR     = 1'b1;
    endtask

    task automatic io_rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        @(negedge CLK);
        bus_if.ADDRESS = addr;
        bus_if.nIORQ   = 1'b0;
        bus_if.nRD     = 1'b0;
        #1;
        chk(tag, bus_if.DATA_OUT, exp);
        bus_if.nIORQ   = 1'b1;
        bus_if.nRD     = 1'b1;
    endtask

    task automatic do_ack(input string tag, input logic [7:0] exp);
        @(negedge CLK);
        bus_if.m1_n  = 1'b0;
        bus_if.nIORQ = 1'b0;
        #1;
        chk({tag, "_oe"}, {7'd0, bus_if.DATA_OE}, 8'h01);
        chk(tag, bus_if.DATA_OUT, exp);
        @(negedge CLK);
        chk({tag, "_hold"}, bus_if.DATA_OUT, exp);
        bus_if.m1_n  = 1'b1;
        bus_if.nIORQ = 1'b1;
    endtask

    task automatic pulse(input logic [7:0] bits);
        @(negedge CLK);
        IRQ_IN = bits;
        @(negedge CLK);
        IRQ_IN = 8'h00;
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        RESET          = 1'b1;
        IRQ_IN         = 8'h00;
        bus_if.ADDRESS = 8'h00;
        bus_if.DATA_IN = 8'h00;
        bus_if.nIORQ   = 1'b1;
        bus_if.nRD     = 1'b1;
        bus_if.nWR     = 1'b1;
        bus_if.m1_n    = 1'b1;
        #12;
        chk("rst_nint", {7'd0, nINT}, 8'h01);
        chk("rst_oe", {7'd0, bus_if.DATA_OE}, 8'h00);
        chk("rst_dout", bus_if.DATA_OUT, 8'h00);
        @(negedge CLK);
        RESET = 1'b0;
        io_rd("rst_mask", 8'hE0, 8'h00);
        io_rd("rst_pend", 8'hE1, 8'h00);
        io_rd("rst_isr", 8'hE2, 8'h00);

        // single source: latency, vector, state update
        io_wr(8'hE0, 8'h04);
        io_rd("mask_rb", 8'hE0, 8'h04);
        IRQ_IN[2] = 1'b1;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK);
            #1;
            lat++;
            if (!nINT) break;
        end
        chk("irq_lat", 8'(lat), 8'(EXP_LAT));
        @(negedge CLK);
        IRQ_IN = 8'h00;
        do_ack("ack2", 8'h04);
        cyc(1);
        chk("ack2_nint", {7'd0, nINT}, 8'h01);
        io_rd("ack2_pend", 8'hE1, 8'h00);
        io_rd("ack2_isr", 8'hE2, 8'h04);
        io_wr(8'hE2, 8'h00);
        io_rd("eoi2_isr", 8'hE2, 8'h00);

        // simultaneous sources: priority and EOI release
        io_wr(8'hE0, 8'hFF);
        pulse(8'h22);
        cyc(5);
        chk("pri_nint", {7'd0, nINT}, 8'h00);
        do_ack("ack1", 8'h02);
        cyc(2);
        chk("blk_nint", {7'd0, nINT}, 8'h01);
        io_rd("ack1_isr", 8'hE2, 8'h02);
        io_rd("ack1_pend", 8'hE1, 8'h20);
        io_wr(8'hE2, 8'h00);
        cyc(5);
        chk("eoi1_nint", {7'd0, nINT}, 8'h00);
        do_ack("ack5", 8'h0A);
        io_rd("ack5_isr", 8'hE2, 8'h20);

        // nesting with source 5 in service
        pulse(8'h40);
        cyc(5);
        chk("low_blk", {7'd0, nINT}, 8'h01);
        pulse(8'h08);
        cyc(5);
        chk("nest_nint", {7'd0, nINT}, 8'h00);
        do_ack("ack3", 8'h06);
        io_rd("nest_isr", 8'hE2, 8'h28);
        io_wr(8'hE2, 8'h00, 3);
        io_rd("eoi_once", 8'hE2, 8'h20);
        cyc(3);
        chk("still_blk", {7'd0, nINT}, 8'h01);
        io_wr(8'hE2, 8'h00);
        cyc(3);
        chk("rel6_nint", {7'd0, nINT}, 8'h00);
        do_ack("ack6", 8'h0C);
        io_wr(8'hE2, 8'h00);
        io_rd("eoi6_isr", 8'hE2, 8'h00);
        cyc(3);
        chk("idle_nint", {7'd0, nINT}, 8'h01);

        // masked pending, W1C, edge vs W1C
        io_wr(8'hE0, 8'h00);
        pulse(8'h01);
        cyc(5);
        chk("msk_nint", {7'd0, nINT}, 8'h01);
        io_rd("msk_pend", 8'hE1, 8'h01);
        io_wr(8'hE1, 8'h01);
        io_rd("w1c_pend", 8'hE1, 8'h00);
        pulse(8'h01);
        cyc(5);
        @(negedge CLK);
        bus_if.ADDRESS = 8'hE1;
        bus_if.DATA_IN = 8'h01;
        bus_if.nIORQ   = 1'b0;
        bus_if.nWR     = 1'b0;
        IRQ_IN         = 8'h01;
        @(negedge CLK);
        bus_if.nIORQ   = 1'b1;
        bus_if.nWR     = 1'b1;
        IRQ_IN         = 8'h00;
        cyc(4);
        io_rd("set_wins", 8'hE1, 8'h01);

        // spurious ack, unused port, undecoded address
        do_ack("spur", 8'hFE);
        io_rd("spur_isr", 8'hE2, 8'h00);
        io_rd("spur_pend", 8'hE1, 8'h01);
        io_rd("port3", 8'hE3, 8'hFF);
        @(negedge CLK);
        bus_if.ADDRESS = 8'h10;
        bus_if.nIORQ   = 1'b0;
        bus_if.nRD     = 1'b0;
        #1;
        chk("nodec_oe", {7'd0, bus_if.DATA_OE}, 8'h00);
        bus_if.nIORQ   = 1'b1;
        bus_if.nRD     = 1'b1;

        // reset in the middle of an ack
        io_wr(8'hE0, 8'hFF);
        cyc(3);
        chk("pre_rst_nint", {7'd0, nINT}, 8'h00);
        @(negedge CLK);
        bus_if.m1_n  = 1'b0;
        bus_if.nIORQ = 1'b0;
        #1;
        chk("mid_oe", {7'd0, bus_if.DATA_OE}, 8'h01);
        #2;
        RESET = 1'b1;
        #1;
        chk("arst_oe", {7'd0, bus_if.DATA_OE}, 8'h00);
        chk("arst_nint", {7'd0, nINT}, 8'h01);
        @(negedge CLK);
        bus_if.m1_n  = 1'b1;
        bus_if.nIORQ = 1'b1;
        RESET        = 1'b0;
        io_rd("arst_mask", 8'hE0, 8'h00);
        io_rd("arst_pend", 8'hE1, 8'h00);
        io_rd("arst_isr", 8'hE2, 8'h00);
        cyc(2);
        chk("arst_nint2", {7'd0, nINT}, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/z80_int_ctrl.md
Name: z80_int_ctrl

Overview:
Vectored interrupt controller that sits directly upstream of the Z80 CPU bus wrapper. It drives the CPU's nINT input and answers the interrupt-acknowledge cycle (m1_n and nIORQ both low) with an IM2 vector byte. It also exposes mask, pending and in-service registers as Z80 I/O ports.
- Eight prioritised peripheral sources; lowest index has the highest priority.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..8)
VEC_BASE, 8'h00, IM2 vector base; vector = VEC_BASE | {idx, 1'b0}
IO_BASE, 8'hE0, I/O port base; ports IO_BASE+0..+2 are decoded, IO_BASE 4-aligned

Ports:
CLK  in  1  system clock, all state on rising edge
RESET  in  1  asynchronous, active-high reset
IRQ_IN  in  NUM_SRC  peripheral requests, rising-edge triggered, synchronous to CLK
ADDRESS  in  8  CPU address low byte (I/O port number)
DATA_IN  in  8  CPU write data (CPU DATA_OUT)
nIORQ  in  1  CPU I/O request, active low
nRD  in  1  CPU read strobe, active low
nWR  in  1  CPU write strobe, active low
m1_n  in  1  CPU M1, active low
DATA_OUT  out  8  vector or register read data
DATA_OE  out  1  high when DATA_OUT must be muxed onto CPU DATA_IN
nINT  out  1  interrupt request to CPU, active low, registered

Behaviour:
- Reset values: mask = 0 (all disabled), pending = 0, in-service (isr) = 0, nINT = 1, DATA_OE = 0, DATA_OUT = 0, edge history = 0.
- Edge detect: pending[i] sets on a cycle where IRQ_IN[i]=1 and its previous sample was 0. A request held high does not re-arm.
- Eligible set: pending & mask, restricted to bits of strictly higher priority (lower index) than the highest-priority isr bit. With isr = 0, all of pending & mask is eligible.
- nINT is registered: low the cycle after eligible is non-empty, high the cycle after it empties.
- Ack cycle: ack = !m1_n & !nIORQ. On the first cycle of ack (rising detect of ack), in one step:
  - latch the winner index (lowest eligible bit);
  - set isr[winner] and clear pending[winner].
- Vector output: while ack is held, DATA_OE = 1 and DATA_OUT = VEC_BASE | {winner, 1'b0}. The vector is frozen for the whole ack.
- Spurious ack: if eligible is empty at ack start, the vector is VEC_BASE | 8'hFE and no state changes.
- I/O decode is active when nIORQ=0 and m1_n=1 and ADDRESS[7:2]==IO_BASE[7:2]. The port offset is ADDRESS[1:0].
  - +0 mask: read/write.
  - +1 pending: read; write-1-to-clear.
  - +2 isr: read; any write is an EOI and clears the highest-priority set isr bit (no effect if isr = 0).
  - +3: reads 8'hFF, writes ignored.
- Reads: DATA_OE = 1 combinationally while decode && nRD=0. Bits at index >= NUM_SRC read as 0.
- Writes: take effect once, on the first cycle of decode && nWR=0 (edge detected), even if nWR stays low for several cycles.
- Simultaneous events:
  - new edge on bit i and ack-clear of pending[i] in the same cycle: set wins;
  - edge and W1C on the same bit: set wins;
  - mask write takes effect the next cycle.
- Masking a bit leaves its pending value intact.
- RESET asserted mid-ack: all state clears immediately, DATA_OE drops asynchronously, nINT = 1.

Optional Feature:
IRQ_SYNC_EN: when defined, each IRQ_IN bit passes through a two-flop synchroniser before edge detect, so IRQ_IN may be asynchronous. Latency from IRQ_IN rise to pending is 3 edges and to nINT low is 4 edges. When undefined, IRQ_IN is sampled directly; pending sets at the first edge and nINT goes low at the second edge.

Test Plan:
- Reset, write mask=8'h04 to port E0, pulse IRQ_IN[2] -> nINT low 2 edges later (feature off); ack cycle -> DATA_OE=1, DATA_OUT=8'h04, pending=0, isr=8'h04, nINT high next cycle.
- Mask=8'hFF, IRQ_IN[5] and IRQ_IN[1] rise together -> first ack vector 8'h02, isr=8'h02; nINT stays high while isr[1] set; EOI write to E2 -> nINT low, second ack vector 8'h0A.
- isr=8'h20 (source 5 in service), IRQ_IN[3] rises -> nINT low (nesting); IRQ_IN[6] instead -> nINT stays high until EOI.
- IRQ_IN[0] rises, mask=0 -> nINT high, read E1 = 8'h01; write 8'h01 to E1 -> read E1 = 8'h00; edge on same cycle as W1C -> pending[0] stays 1.
- Ack with nothing eligible -> DATA_OUT=8'hFE, isr unchanged; RESET pulsed during ack -> DATA_OE=0 at once, all registers 0.
- IRQ_SYNC_EN defined -> nINT low exactly 4 edges after IRQ_IN rise.
